// File: rtl/multicore_pkg.sv
// Shared types for the fetch front end.
//   RESET_PC_DEFAULT : PC fetched first after reset
//   FETCH_BUF_DEPTH  : instruction buffer depth (only 2 is supported)
//   fetch_state_t    : request tracker state (IDLE / WAIT / DRAIN)
//   fetch_entry_t    : one buffered instruction {pc, instr}
package multicore_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FETCH_BUF_DEPTH  = 2;

  // IDLE  : nothing outstanding at the cache
  // WAIT  : one request outstanding, its response will be kept
  // DRAIN : one request outstanding, its response is stale and dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched instructions.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   flush_i       : drop all entries (wins over push/pop)
//   push_i        : write push_data_i at the tail
//   pop_i         : retire the head
//   count_o       : number of valid entries (0..2)
//   head_o        : head entry (contents meaningless when count_o == 0)
module fetch_buffer
  import multicore_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q;
    if (flush_i)               count_d = 2'd0;
    else if (push_i && !pop_i) count_d = count_q + 2'd1;
    else if (!push_i && pop_i) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        // Storage is left as is; only the pointers matter once empty.
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push_i) begin
          mem_q[wr_ptr_q] <= push_data_i;
          wr_ptr_q        <= ~wr_ptr_q;
        end
        if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one cache request at a time, tracks whether the
// outstanding response is still wanted after a redirect, and buffers
// returned instructions for decode.
//   i_aclk, i_reset         : clock, synchronous active-high reset
//   i_fetch_en              : permit to issue new requests
//   i_br_valid, i_br_addr   : redirect strobe and target (bits [1:0] ignored)
//   i_decode_en             : decode accepts the head when o_instr_valid
//   o_icache_req/addr       : request handshake towards the I-cache
//   i_icache_ready          : cache accepts the request this cycle
//   i_icache_rvalid/rdata   : one response per accepted request
//   o_instr_valid/instr/pc  : buffer head presented to decode
module fetch_unit
  import multicore_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic        i_aclk,
  input  logic        i_reset,
  input  logic        i_fetch_en,
  input  logic        i_br_valid,
  input  logic [31:0] i_br_addr,
  input  logic        i_decode_en,
  output logic        o_icache_req,
  output logic [31:0] o_icache_addr,
  input  logic        i_icache_ready,
  input  logic        i_icache_rvalid,
  input  logic [31:0] i_icache_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  localparam logic [1:0] BUF_FULL = 2'(BUF_DEPTH);

  fetch_state_t state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  req_pc_q;

  logic [1:0]   buf_count;
  fetch_entry_t buf_head;
  fetch_entry_t push_entry;
  logic         req;
  logic         accept;
  logic         push;
  logic         pop;
  logic [31:0]  br_target;
  logic         br_addr_lsb_unused;

  assign br_target          = {i_br_addr[31:2], 2'b00};
  assign br_addr_lsb_unused = ^i_br_addr[1:0];

  // Request only from IDLE so at most one request is ever in flight. The
  // buffer check uses the registered count: with nothing outstanding, a
  // count below full guarantees the eventual response has a slot. A redirect
  // withdraws the request in the same cycle so the stale PC is never sent.
  assign req    = ~i_reset & (state_q == IDLE) & i_fetch_en & ~i_br_valid
                & (buf_count < BUF_FULL);
  assign accept = req & i_icache_ready;

  // Responses are kept only in WAIT; a redirect in the same cycle kills it.
  assign push       = (state_q == WAIT) & i_icache_rvalid & ~i_br_valid;
  assign push_entry = '{pc: req_pc_q, instr: i_icache_rdata};

  assign o_instr_valid = (buf_count != 2'd0) & ~i_br_valid;
  assign pop           = o_instr_valid & i_decode_en;

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      req_pc_q   <= '0;
    end else begin
      if (i_br_valid)  fetch_pc_q <= br_target;
      else if (accept) fetch_pc_q <= fetch_pc_q + 32'd4;  // wraps to 0
      if (accept)      req_pc_q   <= fetch_pc_q;

      unique case (state_q)
        IDLE:  if (accept) state_q <= WAIT;
        WAIT: begin
          if (i_br_valid)           state_q <= i_icache_rvalid ? IDLE : DRAIN;
          else if (i_icache_rvalid) state_q <= IDLE;
        end
        DRAIN: if (i_icache_rvalid) state_q <= IDLE;
        default:                    state_q <= IDLE;
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk_i       (i_aclk),
    .rst_i       (i_reset),
    .flush_i     (i_br_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (buf_count),
    .head_o      (buf_head)
  );

  assign o_icache_req  = req;
  assign o_icache_addr = fetch_pc_q;
  assign o_instr       = buf_head.instr;
  assign o_pc          = buf_head.pc;

endmodule
